// File: rtl/seq_alu_if.sv
// Handshake and data bus of the sequential ALU.
// Master (control FSM / testbench) drives start, op, opa, opb, shamt,
// cin_en and carry_we. Slave (seq_alu) drives busy, done, result,
// carry_out and carry_flag.
interface seq_alu_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) ();
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic [SHW-1:0]   shamt;
  logic             cin_en;
  logic             carry_we;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             carry_flag;

  modport master (
    output start, op, opa, opb, shamt, cin_en, carry_we,
    input  busy, done, result, carry_out, carry_flag
  );

  modport slave (
    input  start, op, opa, opb, shamt, cin_en, carry_we,
    output busy, done, result, carry_out, carry_flag
  );
endinterface

// File: rtl/seq_alu.sv
// Registered ALU: ADD/SUB/INC/DEC/SHR complete in one cycle, MUL is a
// WIDTH-cycle shift-add. start/busy/done handshake, stored carry flag.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous, active-high reset
//   bus   - seq_alu_if.slave (start/op/operands in; busy/done/result/
//           carry_out/carry_flag out, all registered)
// Optional feature: define SEQ_ALU_EARLY_TERM_EN to end MUL as soon as
// the remaining multiplier bits are all zero.
module seq_alu #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SHW   = $clog2(WIDTH)
) (
  input  logic       clk,
  input  logic       reset,
  seq_alu_if.slave   bus
);

  localparam int unsigned AW = 2 * WIDTH;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_INC = 3'b010;
  localparam logic [2:0] OP_DEC = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_SHR = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic             carry_we_q, carry_we_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             carry_out_q, carry_out_d;
  logic             carry_flag_q, carry_flag_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   sum;
  logic [AW-1:0]    acc_nxt;
  logic             cin;
  logic             mul_last;

  // Single-cycle datapath on the live inputs (used only at the accept edge)
  always_comb begin
    cin = bus.cin_en & carry_flag_q;
    sum = '0;
    case (bus.op)
      OP_ADD:  sum = {1'b0, bus.opa} + {1'b0, bus.opb} + (WIDTH+1)'(cin);
      OP_SUB:  sum = {1'b0, bus.opa} - {1'b0, bus.opb} + (WIDTH+1)'(cin);
      OP_INC:  sum = {1'b0, bus.opa} + (WIDTH+1)'(1);
      OP_DEC:  sum = {1'b0, bus.opa} - (WIDTH+1)'(1);
      OP_SHR:  sum = {1'b0, bus.opa >> bus.shamt};
      default: sum = '0;
    endcase
  end

  // Next state, datapath updates and registered-output next values
  always_comb begin
    state_d      = state_q;
    acc_d        = acc_q;
    mcand_d      = mcand_q;
    mplier_d     = mplier_q;
    cnt_d        = cnt_q;
    carry_we_d   = carry_we_q;
    result_d     = result_q;
    carry_out_d  = carry_out_q;
    carry_flag_d = carry_flag_q;
    acc_nxt      = acc_q;
    mul_last     = 1'b0;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (bus.start) begin
          carry_we_d = bus.carry_we;
          if (bus.op == OP_MUL) begin
`ifdef SEQ_ALU_EARLY_TERM_EN
            if (bus.opa == '0) begin
              state_d     = S_DONE;
              result_d    = '0;
              carry_out_d = 1'b0;
              if (bus.carry_we) carry_flag_d = 1'b0;
            end else begin
              state_d  = S_MUL;
              acc_d    = '0;
              mcand_d  = bus.opb;
              mplier_d = bus.opa;
              cnt_d    = '0;
            end
`else
            state_d  = S_MUL;
            acc_d    = '0;
            mcand_d  = bus.opb;
            mplier_d = bus.opa;
            cnt_d    = '0;
`endif
          end else begin
            state_d     = S_DONE;
            result_d    = sum[WIDTH-1:0];
            carry_out_d = sum[WIDTH];
            if (bus.carry_we) carry_flag_d = sum[WIDTH];
          end
        end
      end

      S_MUL: begin
        acc_nxt  = acc_q + (mplier_q[0] ? (AW'(mcand_q) << cnt_q) : AW'(0));
        acc_d    = acc_nxt;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + SHW'(1);
`ifdef SEQ_ALU_EARLY_TERM_EN
        mul_last = (cnt_q == SHW'(WIDTH - 1)) || (mplier_d == '0);
`else
        mul_last = (cnt_q == SHW'(WIDTH - 1));
`endif
        if (mul_last) begin
          state_d     = S_DONE;
          result_d    = acc_nxt[WIDTH-1:0];
          carry_out_d = acc_nxt[WIDTH];
          if (carry_we_q) carry_flag_d = acc_nxt[WIDTH];
        end
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_MUL);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers; reset discards any in-flight MUL
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      acc_q        <= '0;
      mcand_q      <= '0;
      mplier_q     <= '0;
      cnt_q        <= '0;
      carry_we_q   <= 1'b0;
      result_q     <= '0;
      carry_out_q  <= 1'b0;
      carry_flag_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      mcand_q      <= mcand_d;
      mplier_q     <= mplier_d;
      cnt_q        <= cnt_d;
      carry_we_q   <= carry_we_d;
      result_q     <= result_d;
      carry_out_q  <= carry_out_d;
      carry_flag_q <= carry_flag_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.result     = result_q;
  assign bus.carry_out  = carry_out_q;
  assign bus.carry_flag = carry_flag_q;

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (WIDTH=16): a vector table of single
// operations followed by hand-written back-to-back, mid-MUL start and
// mid-MUL reset sequences.
module tb_seq_alu;

  localparam int unsigned WIDTH = 16;
  localparam int MAXCYC = 64;

`ifdef SEQ_ALU_EARLY_TERM_EN
  localparam int LAT_M100  = 10;  // opa=0x0100: multiplier empties after 9 cycles
  localparam int LAT_M300  = 10;  // opa=300: top set bit is bit 8
  localparam int LAT_M5    = 4;
  localparam int LAT_M0    = 1;
`else
  localparam int LAT_M100  = 17;
  localparam int LAT_M300  = 17;
  localparam int LAT_M5    = 17;
  localparam int LAT_M0    = 17;
`endif
  localparam int LAT_MFFFF = 17;

  logic clk;
  logic reset;

  seq_alu_if #(.WIDTH(WIDTH)) bus ();

  seq_alu #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  sh;
    logic        cin;
    logic        we;
    logic [15:0] res;
    logic        co;
    logic        cf;
    int          lat;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] op_v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, input logic cin, input logic we);
    bus.start    = 1'b1;
    bus.op       = op_v;
    bus.opa      = a;
    bus.opb      = b;
    bus.shamt    = sh;
    bus.cin_en   = cin;
    bus.carry_we = we;
  endtask

  // Issue one op, return once done is seen (sampled #1 after the edge)
  task automatic issue(input logic [2:0] op_v, input logic [15:0] a, input logic [15:0] b,
                       input logic [3:0] sh, input logic cin, input logic we,
                       output int lat, output int bcnt);
    @(negedge clk);
    drive(op_v, a, b, sh, cin, we);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat  = 1;
    bcnt = 0;
    while (!bus.done && lat < MAXCYC) begin
      if (bus.busy) bcnt++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, pulses;
    string tag;

    vecs[0]  = '{3'b000, 16'hFFFF, 16'h0001, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1};
    vecs[1]  = '{3'b000, 16'h0010, 16'h0020, 4'd0,  1'b1, 1'b0, 16'h0031, 1'b0, 1'b1, 1};
    vecs[2]  = '{3'b001, 16'h0003, 16'h0005, 4'd0,  1'b0, 1'b0, 16'hFFFE, 1'b1, 1'b1, 1};
    vecs[3]  = '{3'b011, 16'h0000, 16'h0000, 4'd0,  1'b0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1};
    vecs[4]  = '{3'b010, 16'hFFFF, 16'h0000, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1};
    vecs[5]  = '{3'b111, 16'h8000, 16'h0000, 4'd15, 1'b0, 1'b0, 16'h0001, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'b100, 16'h1234, 16'h5678, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 1};
    vecs[7]  = '{3'b001, 16'h0010, 16'h0003, 4'd0,  1'b0, 1'b1, 16'h000D, 1'b0, 1'b0, 1};
    vecs[8]  = '{3'b000, 16'h1234, 16'h4321, 4'd0,  1'b1, 1'b0, 16'h5555, 1'b0, 1'b0, 1};
    vecs[9]  = '{3'b101, 16'hAAAA, 16'h5555, 4'd3,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1};
    vecs[10] = '{3'b110, 16'h0100, 16'h0100, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, LAT_M100};
    vecs[11] = '{3'b110, 16'd300,  16'd200,  4'd0,  1'b0, 1'b0, 16'hEA60, 1'b0, 1'b1, LAT_M300};
    vecs[12] = '{3'b001, 16'h0005, 16'h0003, 4'd0,  1'b1, 1'b0, 16'h0003, 1'b0, 1'b1, 1};
    vecs[13] = '{3'b110, 16'd5,    16'd3,    4'd0,  1'b0, 1'b0, 16'h000F, 1'b0, 1'b1, LAT_M5};
    vecs[14] = '{3'b110, 16'd0,    16'd7,    4'd0,  1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, LAT_M0};
    vecs[15] = '{3'b110, 16'hFFFF, 16'hFFFF, 4'd0,  1'b0, 1'b1, 16'h0001, 1'b0, 1'b0, LAT_MFFFF};
    vecs[16] = '{3'b000, 16'h8000, 16'h8000, 4'd0,  1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 1};
    vecs[17] = '{3'b001, 16'h0005, 16'h0005, 4'd0,  1'b1, 1'b1, 16'h0001, 1'b0, 1'b0, 1};

    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.op       = 3'b000;
    bus.opa      = '0;
    bus.opb      = '0;
    bus.shamt    = '0;
    bus.cin_en   = 1'b0;
    bus.carry_we = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("reset_busy",  32'(bus.busy), 32'd0);
    check("reset_done",  32'(bus.done), 32'd0);
    check("reset_res",   32'(bus.result), 32'd0);
    check("reset_cout",  32'(bus.carry_out), 32'd0);
    check("reset_cflag", 32'(bus.carry_flag), 32'd0);

    for (int i = 0; i < NVEC; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].cin, vecs[i].we, lat, bcnt);
      tag = $sformatf("v%0d", i);
      check({tag, "_lat"},   32'(lat), 32'(vecs[i].lat));
      check({tag, "_busy"},  32'(bcnt), 32'(vecs[i].lat - 1));
      check({tag, "_res"},   32'(bus.result), 32'(vecs[i].res));
      check({tag, "_cout"},  32'(bus.carry_out), 32'(vecs[i].co));
      check({tag, "_cflag"}, 32'(bus.carry_flag), 32'(vecs[i].cf));
    end

    // Back-to-back: SHR issued in the DONE cycle of an ADD
    issue(3'b000, 16'h0001, 16'h0002, 4'd0, 1'b0, 1'b0, lat, bcnt);
    check("b2b_first_res", 32'(bus.result), 32'h0003);
    drive(3'b111, 16'h8000, 16'h0000, 4'd15, 1'b0, 1'b0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("b2b_done",  32'(bus.done), 32'd1);
    check("b2b_res",   32'(bus.result), 32'h0001);
    check("b2b_cout",  32'(bus.carry_out), 32'd0);
    @(posedge clk); #1;
    check("b2b_done_drop", 32'(bus.done), 32'd0);

    // MUL with a start pulse and operand changes while busy
    @(negedge clk);
    drive(3'b110, 16'h0100, 16'h0100, 4'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    while (!bus.done && lat < MAXCYC) begin
      if (lat == 5) drive(3'b000, 16'h0001, 16'h0001, 4'd0, 1'b0, 1'b0);
      if (lat == 6) bus.start = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    check("midstart_lat",   32'(lat), 32'(LAT_M100));
    check("midstart_res",   32'(bus.result), 32'h0000);
    check("midstart_cout",  32'(bus.carry_out), 32'd1);
    check("midstart_cflag", 32'(bus.carry_flag), 32'd1);

    // Put a nonzero result and a set flag in place, then reset mid-MUL
    issue(3'b000, 16'hFFFF, 16'h0002, 4'd0, 1'b0, 1'b1, lat, bcnt);
    check("pre_rst_res",   32'(bus.result), 32'h0001);
    check("pre_rst_cflag", 32'(bus.carry_flag), 32'd1);
    @(negedge clk);
    drive(3'b110, 16'd300, 16'd200, 4'd0, 1'b0, 1'b1);
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_busy_before", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_mid_busy",  32'(bus.busy), 32'd0);
    check("rst_mid_done",  32'(bus.done), 32'd0);
    check("rst_mid_res",   32'(bus.result), 32'd0);
    check("rst_mid_cout",  32'(bus.carry_out), 32'd0);
    check("rst_mid_cflag", 32'(bus.carry_flag), 32'd0);
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (bus.done || bus.busy) pulses++;
    end
    check("rst_mid_no_done", 32'(pulses), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, registered successor to the combinational datapath ALU.
- Executes ADD/SUB/INC/DEC/SHR in one cycle; MUL is a multi-cycle shift-add operation.
- Uses a start/busy/done handshake and holds an internal carry flag register.
- Sits between the register file read ports and the writeback mux; the control FSM pulses start and waits for done before writeback.

Parameters:
- WIDTH, 16, operand/result width in bits (>=4).
- SHW, $clog2(WIDTH), shift-amount width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request; accepted when busy=0.
- op  in  3  000 ADD, 001 SUB, 010 INC, 011 DEC, 110 MUL, 111 SHR; 100/101 reserved.
- opa  in  WIDTH  operand A (inreg1 equivalent).
- opb  in  WIDTH  operand B (inreg2 equivalent).
- shamt  in  SHW  right-shift amount for SHR.
- cin_en  in  1  ADD/SUB add the stored carry flag when 1.
- carry_we  in  1  update the carry flag on completion.
- busy  out  1  high while MUL iterates.
- done  out  1  one-cycle completion pulse.
- result  out  WIDTH  registered result, held until the next accepted start.
- carry_out  out  1  carry/borrow bit of the last operation, held.
- carry_flag  out  1  stored carry flag.

Behaviour:
- Reset: state IDLE; busy, done, result, carry_out and carry_flag all 0. Reset overrides everything, including an in-flight MUL, which is discarded.
- FSM states: IDLE, MUL, DONE.
- start is accepted in IDLE or DONE (back-to-back issue is allowed). In MUL, start is ignored and no state changes.
- Operands, op, cin_en and carry_we are captured at the accepting edge. Later input changes have no effect on the running operation.
- Single-cycle ops: the (WIDTH+1)-bit sum s is computed and registered at the accept edge. State goes to DONE, so done=1 in the next cycle (latency 1).
  - ADD: s = {0,opa} + {0,opb} + c.
  - SUB: s = {0,opa} - {0,opb} + c, with c = cin_en ? carry_flag : 0.
  - INC: s = {0,opa} + 1. DEC: s = {0,opa} - 1.
  - result = s[WIDTH-1:0]; carry_out = s[WIDTH].
  - SUB/DEC carry_out=1 means borrow; e.g. DEC of 0 gives result all-ones, carry_out 1.
- SHR: result = opa >> shamt (logical); carry_out = 0.
- Reserved op: result = 0, carry_out = 0, latency 1.
- MUL:
  - Accept edge loads the accumulator (2*WIDTH bits) with 0, the multiplicand with opb, and the multiplier with opa; counter = 0.
  - Each MUL cycle: if multiplier LSB is 1, acc += multiplicand << counter. Then multiplier >>= 1 and counter++.
  - After WIDTH MUL cycles, go to DONE. result = acc[WIDTH-1:0]; carry_out = acc[WIDTH].
  - Latency: done asserts WIDTH+1 cycles after the accept edge; busy=1 for exactly WIDTH cycles.
- DONE state: done=1 for one cycle. Without a new start, the next state is IDLE. result/carry_out stay stable until the next accepted operation completes.
- Carry flag: on entry to DONE, if the captured carry_we=1, carry_flag <= carry_out. Otherwise it is unchanged.
- Simultaneous start in DONE: done=1 for that cycle, and the new operation is accepted at the same edge.

Optional Feature:
- Macro SEQ_ALU_EARLY_TERM_EN.
- When defined, MUL goes to DONE at the end of the first MUL cycle where the shifted multiplier becomes 0, or after WIDTH cycles, whichever comes first. A zero multiplier at accept goes directly to DONE (latency 1, result 0). Result is bit-identical to the full iteration; only latency and busy duration change.
- When undefined, MUL latency is always WIDTH+1.

Test Plan:
- Reset mid-MUL: start MUL 300*200, assert reset on cycle 5 -> next cycle busy=0, done=0, result=0, carry_flag=0; no done pulse afterwards.
- ADD with carry: carry_flag=1 (set via prior ADD 0xFFFF+0x0001, carry_we=1 -> result 0x0000, carry_out 1); then ADD 0x0010+0x0020, cin_en=1 -> done after 1 cycle, result 0x0031, carry_out 0.
- SUB borrow and DEC wrap: SUB 0x0003-0x0005, cin_en=0 -> result 0xFFFE, carry_out 1; DEC 0x0000 -> 0xFFFF, carry_out 1.
- MUL, WIDTH=16, no macro: 0x0100*0x0100 -> done exactly 17 cycles after start, result 0x0000, carry_out 1; busy high 16 cycles; a start pulsed mid-MUL is ignored.
- Early-term (macro defined): MUL opa=5, opb=3 -> done 4 cycles after start, result 15; opa=0 -> done after 1 cycle, result 0.
- Back-to-back and SHR: start SHR 0x8000 shamt=15 in the DONE cycle of a prior op -> done next cycle, result 0x0001, carry_out 0; reserved op 100 -> result 0, done after 1 cycle.
